seg_scroll_ctrl: RTL and testbench



---
 rtl/seg_scroll_ctrl.sv | 137 +++++++++++++
 tb/tb_seg_scroll_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scroll_ctrl.sv
// Message buffer, right-to-left scroll sequencer and digit-scan controller for a multiplexed 7-segment bank.
// Optional SEG_SCROLL_LOOP_EN: repeat the message forever instead of returning to IDLE after one pass.
module seg_scroll_ctrl #(
  parameter int NUM_DIGITS    = 4,
  parameter int MSG_DEPTH     = 16,
  parameter int SCAN_DIV      = 50000,
  parameter int SCROLL_FRAMES = 25
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            in_char,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  msg_end,
  input  logic                  clear,
  output logic [7:0]            disp_char,
  output logic [NUM_DIGITS-1:0] digit_an,
  output logic                  busy
);

  localparam int LW = $clog2(MSG_DEPTH + 1);
  localparam int IW = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;
  localparam int OW = $clog2(MSG_DEPTH + NUM_DIGITS + 1);
  localparam int PW = OW + 1;
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SCROLL} state_t;

  state_t        state, state_next;
  logic [LW-1:0] len, len_next;
  logic [OW-1:0] offset, offset_next;
  logic [7:0]    msg_buf [MSG_DEPTH];

  logic [SW-1:0] scan_cnt;
  logic [DW-1:0] digit_idx;
  logic [FW-1:0] frame_cnt;
  logic          scan_wrap, digit_wrap, step;
  logic          xfer, pass_done;
  logic [PW-1:0] pos_sum, pos;
  logic [7:0]    sel_char;

  assign scan_wrap  = (scan_cnt == SW'(SCAN_DIV - 1));
  assign digit_wrap = scan_wrap && (digit_idx == DW'(NUM_DIGITS - 1));
  assign step       = digit_wrap && (frame_cnt == FW'(SCROLL_FRAMES - 1));

  assign in_ready  = (state != SCROLL) && (len < LW'(MSG_DEPTH));
  assign xfer      = in_valid && in_ready && !clear;
  assign pass_done = (PW'(offset) + PW'(1)) == (PW'(len) + PW'(NUM_DIGITS));

  // Scan timing free-runs in every state so the display never stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
      frame_cnt <= '0;
    end else if (scan_wrap) begin
      scan_cnt  <= '0;
      digit_idx <= digit_wrap ? '0 : digit_idx + DW'(1);
      if (digit_wrap)
        frame_cnt <= step ? '0 : frame_cnt + FW'(1);
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      len    <= '0;
      offset <= '0;
    end else begin
      state  <= state_next;
      len    <= len_next;
      offset <= offset_next;
    end
  end

  always_comb begin
    state_next  = state;
    len_next    = len;
    offset_next = offset;
    if (clear) begin
      state_next  = IDLE;
      len_next    = '0;
      offset_next = '0;
    end else if (xfer) begin
      len_next = len + LW'(1);
      if (msg_end || (len_next == LW'(MSG_DEPTH))) begin
        state_next  = SCROLL;
        offset_next = '0;
      end else begin
        state_next = LOAD;
      end
    end else if ((state == SCROLL) && step) begin
      if (pass_done) begin
`ifdef SEG_SCROLL_LOOP_EN
        offset_next = '0;
`else
        state_next  = IDLE;
        len_next    = '0;
        offset_next = '0;
`endif
      end else begin
        offset_next = offset + OW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (xfer)
      msg_buf[len[IW-1:0]] <= in_char;
  end

  // Digit i shows message position offset + i - NUM_DIGITS; kept unsigned by testing the sum first.
  always_comb begin
    pos_sum  = PW'(offset) + PW'(digit_idx);
    pos      = pos_sum - PW'(NUM_DIGITS);
    sel_char = 8'h20;
    if ((state == SCROLL) && (pos_sum >= PW'(NUM_DIGITS)) && (pos < PW'(len)))
      sel_char = msg_buf[pos[IW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_an  <= '1;
      disp_char <= 8'h20;
      busy      <= 1'b0;
    end else begin
      digit_an  <= ~(NUM_DIGITS'(1) << digit_idx);
      disp_char <= sel_char;
      busy      <= (state_next == SCROLL);
    end
  end

endmodule

// File: tb/tb_seg_scroll_ctrl.sv
// Scoreboard bench for seg_scroll_ctrl: 4 digits, 8-char buffer, 4-cycle slots, 2 frames per step (32 cycles).
module tb_seg_scroll_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_char;
  logic       in_valid;
  logic       in_ready;
  logic       msg_end;
  logic       clear;
  logic [7:0] disp_char;
  logic [3:0] digit_an;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int unsigned cyc;

`ifdef SEG_SCROLL_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  typedef struct packed {
    logic [3:0][7:0] ch;
    logic            busy;
    logic            rdy;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] msg_m [8];
  int         msg_len;

  seg_scroll_ctrl #(
    .NUM_DIGITS(4), .MSG_DEPTH(8), .SCAN_DIV(4), .SCROLL_FRAMES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_char(in_char), .in_valid(in_valid),
    .in_ready(in_ready), .msg_end(msg_end), .clear(clear),
    .disp_char(disp_char), .digit_an(digit_an), .busy(busy)
  );

  always #5 clk = ~clk;

  // Edges since reset release; the scan position is a pure function of this.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected frame at scroll step j of the message in msg_m/msg_len.
  task automatic push_steps(input int first, input int last);
    for (int j = first; j <= last; j++) begin
      exp_t e;
      bit   ended;
      int   eff;
      ended  = !LOOP && (j >= msg_len + 4);
      eff    = LOOP ? (j % (msg_len + 4)) : j;
      e.busy = !ended;
      e.rdy  = ended;
      for (int i = 0; i < 4; i++) begin
        int p;
        p = eff + i - 4;
        e.ch[i] = (!ended && p >= 0 && p < msg_len) ? msg_m[p] : 8'h20;
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic push_blank_idle();
    exp_t e;
    e.ch   = {4{8'h20}};
    e.busy = 1'b0;
    e.rdy  = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic sync_window();
    do @(negedge clk); while (cyc % 32 != 0);
  endtask

  // Waits for the frame starting after edge (32n+phase), pops one expectation and compares all four slots.
  task automatic check_frame(input int phase);
    exp_t e;
    do @(negedge clk); while (cyc % 32 != phase);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: frame at cyc %0d has no expectation", cyc);
      return;
    end
    e = exp_q.pop_front();
    for (int s = 0; s < 4; s++) begin
      repeat ((s == 0) ? 1 : 4) @(negedge clk);
      checks++;
      if (digit_an !== (4'b1111 ^ (4'b0001 << s))) begin
        errors++;
        $display("FAIL frame_an slot %0d cyc %0d: got %b want %b", s, cyc, digit_an, 4'b1111 ^ (4'b0001 << s));
      end
      checks++;
      if (disp_char !== e.ch[s]) begin
        errors++;
        $display("FAIL frame_char slot %0d cyc %0d: got %h want %h", s, cyc, disp_char, e.ch[s]);
      end
      if (s == 0) begin
        checks++;
        if (busy !== e.busy) begin
          errors++;
          $display("FAIL frame_busy cyc %0d: got %b want %b", cyc, busy, e.busy);
        end
        checks++;
        if (in_ready !== e.rdy) begin
          errors++;
          $display("FAIL frame_ready cyc %0d: got %b want %b", cyc, in_ready, e.rdy);
        end
      end
    end
  endtask

  task automatic send_char(input logic [7:0] c, input bit last, input bit exp_rdy);
    in_char  = c;
    in_valid = 1'b1;
    msg_end  = last;
    checks++;
    if (in_ready !== exp_rdy) begin
      errors++;
      $display("FAIL send_ready char %h: got %b want %b", c, in_ready, exp_rdy);
    end
    @(negedge clk);
    in_valid = 1'b0;
    msg_end  = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_char = 8'h00; in_valid = 1'b0; msg_end = 1'b0; clear = 1'b0;
    repeat (3) @(negedge clk);
    checks += 4;
    if (digit_an !== 4'b1111) begin errors++; $display("FAIL reset_an: got %b want 1111", digit_an); end
    if (disp_char !== 8'h20) begin errors++; $display("FAIL reset_char: got %h want 20", disp_char); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst_n = 1'b1;
    @(negedge clk);
    checks += 2;
    if (digit_an !== 4'b1110) begin errors++; $display("FAIL first_an: got %b want 1110", digit_an); end
    if (disp_char !== 8'h20) begin errors++; $display("FAIL first_char: got %h want 20", disp_char); end
    repeat (3) @(negedge clk);
    checks++;
    if (digit_an !== 4'b1110) begin errors++; $display("FAIL hold_an: got %b want 1110", digit_an); end
    @(negedge clk);
    checks++;
    if (digit_an !== 4'b1101) begin errors++; $display("FAIL second_an: got %b want 1101", digit_an); end
  endtask

  // Covers the single pass to IDLE by default and the repeat under SEG_SCROLL_LOOP_EN.
  task automatic test_scroll_hi();
    sync_window();
    msg_m[0] = 8'h48; msg_m[1] = 8'h49; msg_len = 2;
    push_steps(0, 8);
    send_char(8'h48, 1'b0, 1'b1);
    send_char(8'h49, 1'b1, 1'b1);
    checks += 2;
    if (busy !== 1'b1) begin errors++; $display("FAIL hi_busy: got %b want 1", busy); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL hi_ready: got %b want 0", in_ready); end
    check_frame(16);
    for (int j = 1; j <= 8; j++) check_frame(0);
    pulse_clear();
  endtask

  task automatic test_overflow();
    sync_window();
    for (int k = 0; k < 8; k++) msg_m[k] = 8'h41 + 8'(k);
    msg_len = 8;
    push_steps(1, 10);
    for (int k = 0; k < 8; k++) send_char(msg_m[k], 1'b0, 1'b1);
    in_char  = 8'h49;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks += 2;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL ovf_ready cycle %0d: got %b want 0", k, in_ready); end
      if (busy !== 1'b1) begin errors++; $display("FAIL ovf_busy cycle %0d: got %b want 1", k, busy); end
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int j = 1; j <= 10; j++) check_frame(0);
  endtask

  task automatic test_clear_mid_scroll();
    clear    = 1'b1;
    in_valid = 1'b1;
    in_char  = 8'h5A;
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("FAIL clr_busy: got %b want 0", busy); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL clr_ready: got %b want 1", in_ready); end
    push_blank_idle();
    check_frame(16);
  endtask

  task automatic test_clear_priority();
    sync_window();
    msg_m[0] = 8'h4B; msg_len = 1;
    push_steps(0, 6);
    send_char(8'h51, 1'b0, 1'b1);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_char  = 8'h5A;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL prio_ready: got %b want 1", in_ready); end
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    send_char(8'h4B, 1'b1, 1'b1);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL prio_busy: got %b want 1", busy); end
    check_frame(16);
    for (int j = 1; j <= 6; j++) check_frame(0);
    pulse_clear();
  endtask

  initial begin
    test_reset();
    test_scroll_hi();
    test_overflow();
    test_clear_mid_scroll();
    test_clear_priority();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
